// File: rtl/updown_key_pulser.sv
// updown_key_pulser: per-button 2-flop sync, stability-count debounce and press-edge detect; arbitrated up/down step pulses.
// Latency: level and pulse appear DEBOUNCE_CYCLES+2 edges after a stable raw change; all outputs registered.
// No backpressure (pulses are fire-and-forget). Optional auto-repeat when UPDOWN_KEY_AUTOREPEAT_EN is defined.
module updown_key_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic up_level,
    output logic down_level,
    output logic conflict
);
    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    // Channel index 0 is the up button, 1 is the down button.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_nxt;
    logic [1:0]    ev;
    state_t        st      [2];
    state_t        st_nxt  [2];
    logic [CW-1:0] cnt     [2];
    logic [CW-1:0] cnt_nxt [2];
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
    logic [1:0]    rpt;
    logic [1:0]    rpt_nxt;
`endif

    assign raw = {btn_down_raw, btn_up_raw};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            lvl_nxt[i] = lvl[i];
            ev[i]      = 1'b0;
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
            rpt_nxt[i] = rpt[i];
`endif
            case (st[i])
                RELEASED: begin
                    if (s2[i]) begin
                        st_nxt[i]  = PRESS_CHK;
                        cnt_nxt[i] = CW'(1);
                    end else begin
                        cnt_nxt[i] = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s2[i]) begin
                        st_nxt[i]  = RELEASED;
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        st_nxt[i]  = HELD;
                        lvl_nxt[i] = 1'b1;
                        ev[i]      = 1'b1;
                        cnt_nxt[i] = '0;
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
                        rpt_nxt[i] = 1'b0;
`endif
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2[i]) begin
                        st_nxt[i]  = RELEASE_CHK;
                        cnt_nxt[i] = CW'(1);
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
                    // rpt selects the long first-repeat wait versus the shorter repeat period.
                    end else if (cnt[i] == (rpt[i] ? CW'(REPEAT_CYCLES - 1) : CW'(HOLD_CYCLES - 1))) begin
                        ev[i]      = 1'b1;
                        cnt_nxt[i] = '0;
                        rpt_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
`else
                    end else begin
                        cnt_nxt[i] = '0;
                    end
`endif
                end
                RELEASE_CHK: begin
                    if (s2[i]) begin
                        st_nxt[i]  = HELD;
                        cnt_nxt[i] = '0;
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
                        rpt_nxt[i] = 1'b0;
`endif
                    end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        st_nxt[i]  = RELEASED;
                        lvl_nxt[i] = 1'b0;
                        cnt_nxt[i] = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    st_nxt[i]  = RELEASED;
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 2'b00;
            s2       <= 2'b00;
            lvl      <= 2'b00;
            up       <= 1'b0;
            down     <= 1'b0;
            conflict <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                st[i]  <= RELEASED;
                cnt[i] <= '0;
            end
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
            rpt      <= 2'b00;
`endif
        end else begin
            s1       <= raw;
            s2       <= s1;
            lvl      <= lvl_nxt;
            up       <= ev[0] & ~ev[1];
            down     <= ev[1] & ~ev[0];
            conflict <= ev[0] & ev[1];
            for (int i = 0; i < 2; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
            rpt      <= rpt_nxt;
`endif
        end
    end

    assign up_level   = lvl[0];
    assign down_level = lvl[1];

endmodule

// File: tb/tb_updown_key_pulser.sv
// Scoreboard bench for updown_key_pulser: stimulus pushes cycle-stamped expected outputs, a monitor pops and compares.
module tb_updown_key_pulser;
    logic clk = 1'b0;
    logic rst;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up;
    logic down;
    logic up_level;
    logic down_level;
    logic conflict;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // exp bit order: {up, down, conflict, up_level, down_level}
    typedef struct {
        int         cyc;
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    updown_key_pulser dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .up           (up),
        .down         (down),
        .up_level     (up_level),
        .down_level   (down_level),
        .conflict     (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int dc, input logic [4:0] e, input string name);
        exp_t t;
        t.cyc  = cyc + dc;
        t.exp  = e;
        t.name = name;
        sb.push_back(t);
    endtask

    // Monitor: runs on the falling edge, away from the active edge.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            act = {up, down, conflict, up_level, down_level};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expected %b at cycle %0d was never observed", e.name, e.exp, e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got {up,down,conflict,up_level,down_level}=%b expected %b",
                             e.name, cyc, act, e.exp);
                end
            end else if (up === 1'b1 || down === 1'b1 || conflict === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d got {up,down,conflict,up_level,down_level}=%b expected no pulse",
                         cyc, act);
            end
        end
    end

    initial begin
        // Reset with both keys high: everything must stay quiet.
        rst          = 1'b0;
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        repeat (3) @(negedge clk);
        expect_at(1, 5'b00000, "reset_outputs");
        btn_down_raw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_at(1, 5'b00000, "no_pulse_after_release");
        expect_at(5, 5'b00000, "reset_release_before_pulse");
        expect_at(6, 5'b10010, "first_up_after_reset");
        expect_at(7, 5'b00010, "up_single_cycle");
        repeat (14) @(negedge clk);
        btn_up_raw = 1'b0;
        expect_at(5, 5'b00010, "up_release_level_hold");
        expect_at(6, 5'b00000, "up_release_level_drop");
        repeat (10) @(negedge clk);

        // Clean down press and release.
        btn_down_raw = 1'b1;
        expect_at(5, 5'b00000, "down_before_pulse");
        expect_at(6, 5'b01001, "down_press");
        expect_at(7, 5'b00001, "down_single_cycle");
        repeat (12) @(negedge clk);
        btn_down_raw = 1'b0;
        expect_at(5, 5'b00001, "down_release_level_hold");
        expect_at(6, 5'b00000, "down_release_level_drop");
        repeat (10) @(negedge clk);

        // Bounce: 3 high, 1 low, 3 high, low -- never reaches the debounce count.
        expect_at(3,  5'b00000, "bounce_a");
        expect_at(6,  5'b00000, "bounce_b");
        expect_at(9,  5'b00000, "bounce_c");
        expect_at(12, 5'b00000, "bounce_d");
        btn_down_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_down_raw = 1'b0;
        @(negedge clk);
        btn_down_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_down_raw = 1'b0;
        repeat (12) @(negedge clk);

        // Simultaneous press: conflict only, both levels set.
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        expect_at(6, 5'b00111, "simul_conflict");
        expect_at(7, 5'b00011, "simul_levels");
        repeat (10) @(negedge clk);
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        expect_at(6, 5'b00000, "simul_release");
        repeat (10) @(negedge clk);

        // Down pressed while up already held: normal down pulse, no conflict.
        btn_up_raw = 1'b1;
        expect_at(6, 5'b10010, "up_first");
        repeat (8) @(negedge clk);
        btn_down_raw = 1'b1;
        expect_at(6, 5'b01011, "down_while_up_held");
        expect_at(7, 5'b00011, "both_held");
        repeat (8) @(negedge clk);
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        expect_at(6, 5'b00000, "both_released");
        repeat (10) @(negedge clk);

        // Reset mid-debounce discards progress; debounce restarts after release.
        btn_up_raw = 1'b1;
        expect_at(6, 5'b00000, "mid_rst_no_pulse");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_at(5, 5'b00000, "mid_rst_still_low");
        expect_at(6, 5'b10010, "mid_rst_pulse");
        repeat (8) @(negedge clk);
        btn_up_raw = 1'b0;
        expect_at(6, 5'b00000, "mid_rst_release");
        repeat (10) @(negedge clk);

`ifdef UPDOWN_KEY_AUTOREPEAT_EN
        // Long hold: press pulse, repeats at +16 then every +8 until release is seen.
        btn_up_raw = 1'b1;
        expect_at(6,  5'b10010, "ar_press");
        expect_at(7,  5'b00010, "ar_press_single");
        expect_at(22, 5'b10010, "ar_first_repeat");
        expect_at(23, 5'b00010, "ar_first_repeat_single");
        expect_at(30, 5'b10010, "ar_repeat_2");
        expect_at(38, 5'b10010, "ar_repeat_3");
        expect_at(46, 5'b10010, "ar_repeat_4");
        repeat (50) @(negedge clk);
        btn_up_raw = 1'b0;
        expect_at(6, 5'b00000, "ar_release");
        repeat (12) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
